// File: rtl/ntt_pkg.sv
// Shared constants and types for the Kyber NTT/INTT layer sequencer.
package ntt_pkg;
    localparam int N_COEF       = 256;
    localparam int N_LAYERS     = 7;
    localparam int BF_PER_LAYER = 128;

    typedef logic [2:0] layer_t;
    typedef logic [7:0] addr_t;
    typedef logic [6:0] zidx_t;
    typedef logic [6:0] bf_cnt_t;
    typedef logic [7:0] outst_t;

    localparam layer_t  LAST_LAYER = layer_t'(N_LAYERS - 1);
    localparam bf_cnt_t LAST_BF    = bf_cnt_t'(BF_PER_LAYER - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} seq_state_t;
endpackage

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address / zeta index generator for one (b, layer) pair.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  bf_cnt_t b,
    input  layer_t  layer,
    input  logic    inverse,
    output addr_t   addr_a,
    output addr_t   addr_b,
    output zidx_t   zeta_idx
);
    logic [3:0] shift;
    addr_t      len;
    addr_t      g;
    addr_t      off;
    addr_t      j;
    zidx_t      zeta_fwd;
    zidx_t      zeta_inv;

    always_comb begin
        // shift = log2(len); g is the butterfly group, off the position inside it
        shift    = 4'd7 - {1'b0, layer};
        len      = addr_t'(1) << shift;
        g        = {1'b0, b} >> shift;
        off      = {1'b0, b} & (len - addr_t'(1));
        j        = (g << (shift + 4'd1)) | off;
        zeta_fwd = (zidx_t'(1) << layer) + g[6:0];
        // wraps mod 128 at layer 6, where 2^(layer+1) itself does not fit
        zeta_inv = (zidx_t'(2) << layer) - zidx_t'(1) - g[6:0];
        addr_a   = j;
        addr_b   = j + len;
        zeta_idx = inverse ? zeta_inv : zeta_fwd;
    end
endmodule

// File: rtl/ntt_layer_seq.sv
// Kyber NTT/INTT layer sequencer: issues 7 layers x 128 butterfly descriptors, one per
// beat, and holds each layer boundary until every issued butterfly has been written back.
module ntt_layer_seq
    import ntt_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  logic   inverse,
    output logic   busy,
    output logic   done,
    output logic   err,
    output logic   bf_valid,
    input  logic   bf_ready,
    output layer_t layer,
    output addr_t  addr_a,
    output addr_t  addr_b,
    output zidx_t  zeta_idx,
    output logic   bf_last,
    input  logic   wb_ack
);
    seq_state_t state, state_nxt;
    bf_cnt_t    bf_cnt, bf_cnt_nxt;
    layer_t     layer_nxt;
    logic       inv_q, inv_nxt;
    outst_t     outst, outst_nxt;
    logic       accept;
    logic       ack_err;
    logic       final_layer;
    addr_t      gen_a;
    addr_t      gen_b;
    zidx_t      gen_z;

    // Fed from the next-cycle counters so the registered descriptor lines up with bf_valid.
    ntt_addr_gen u_addr_gen (
        .b        (bf_cnt_nxt),
        .layer    (layer_nxt),
        .inverse  (inv_nxt),
        .addr_a   (gen_a),
        .addr_b   (gen_b),
        .zeta_idx (gen_z)
    );

    always_comb begin
        accept      = bf_valid && bf_ready;
        ack_err     = wb_ack && !accept && (outst == '0);
        final_layer = inv_q ? (layer == '0) : (layer == LAST_LAYER);

        case ({accept, wb_ack})
            2'b10:   outst_nxt = outst + outst_t'(1);
            2'b01:   outst_nxt = ack_err ? outst : outst - outst_t'(1);
            default: outst_nxt = outst;
        endcase

        state_nxt  = state;
        bf_cnt_nxt = bf_cnt;
        layer_nxt  = layer;
        inv_nxt    = inv_q;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = ISSUE;
                    bf_cnt_nxt = '0;
                    inv_nxt    = inverse;
                    layer_nxt  = inverse ? LAST_LAYER : '0;
                end
            end
            ISSUE: begin
                if (accept) begin
                    if (bf_cnt == LAST_BF) state_nxt = DRAIN;
                    else                   bf_cnt_nxt = bf_cnt + bf_cnt_t'(1);
                end
            end
            DRAIN: begin
                // outst_nxt already counts a write-back landing this cycle
                if (outst_nxt == '0) begin
                    if (final_layer) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt  = ISSUE;
                        bf_cnt_nxt = '0;
                        layer_nxt  = inv_q ? layer - layer_t'(1) : layer + layer_t'(1);
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            bf_cnt   <= '0;
            inv_q    <= 1'b0;
            outst    <= '0;
            err      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bf_valid <= 1'b0;
            layer    <= '0;
            addr_a   <= '0;
            addr_b   <= '0;
            zeta_idx <= '0;
            bf_last  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bf_cnt   <= bf_cnt_nxt;
            inv_q    <= inv_nxt;
            outst    <= outst_nxt;
            err      <= (err && !(state == IDLE && start)) || ack_err;
            busy     <= (state_nxt == ISSUE) || (state_nxt == DRAIN);
            done     <= (state_nxt == DONE);
            bf_valid <= (state_nxt == ISSUE);
            layer    <= layer_nxt;
            addr_a   <= gen_a;
            addr_b   <= gen_b;
            zeta_idx <= gen_z;
            bf_last  <= (state_nxt == ISSUE) && (bf_cnt_nxt == LAST_BF);
        end
    end
endmodule

// File: tb/tb_ntt_layer_seq.sv
// Bench for ntt_layer_seq: golden descriptors are queued at start and popped by a
// monitor on every accepted beat; directed checks cover latency, drain, errors and reset.
module tb_ntt_layer_seq;
    logic       clk = 1'b0;
    logic       rst_n, start, inverse, bf_ready, wb_ack;
    logic       busy, done, err, bf_valid, bf_last;
    logic [2:0] layer;
    logic [7:0] addr_a, addr_b;
    logic [6:0] zeta_idx;

    int checks = 0;
    int failures = 0;
    int accepted_cnt = 0;
    int acked_cnt = 0;
    int ack_mode = 2;      // 0: ack one pending beat per cycle, 1: hold acks, 2: main drives wb_ack
    bit rdy_rand = 1'b0;
    int at;
    logic [26:0] exp_q[$];
    logic [26:0] seen[$];

    ntt_layer_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
        .busy(busy), .done(done), .err(err),
        .bf_valid(bf_valid), .bf_ready(bf_ready), .layer(layer),
        .addr_a(addr_a), .addr_b(addr_b), .zeta_idx(zeta_idx),
        .bf_last(bf_last), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [26:0] pack(input int l, input int a, input int b, input int z, input bit last);
        return {3'(l), 8'(a), 8'(b), 7'(z), last};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_desc(input string name, input logic [26:0] act, input logic [26:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got L%0d a=%0d b=%0d z=%0d last=%0d, want L%0d a=%0d b=%0d z=%0d last=%0d",
                     name, act[26:24], act[23:16], act[15:8], act[7:1], act[0],
                     exp[26:24], exp[23:16], exp[15:8], exp[7:1], exp[0]);
        end
    endtask

    // Textbook Kyber loop nest: groups by start index, zeta counter stepping per group.
    task automatic push_golden(input bit inv);
        int k, ln, cnt, l;
        k = inv ? 127 : 1;
        for (int s = 0; s < 7; s++) begin
            l   = inv ? 6 - s : s;
            ln  = 128 >> l;
            cnt = 0;
            for (int st = 0; st < 256; st += 2 * ln) begin
                for (int j = st; j < st + ln; j++) begin
                    cnt++;
                    exp_q.push_back(pack(l, j, j + ln, k, cnt == 128));
                end
                k = inv ? k - 1 : k + 1;
            end
        end
    endtask

    // Monitor: scoreboard pop on every accepted beat, plus hold check while stalled.
    initial begin
        logic [26:0] cur, held, e;
        bit prev_stall;
        prev_stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            cur = {layer, addr_a, addr_b, zeta_idx, bf_last};
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid_held", bf_valid, 1);
                    check_desc("stall_desc_held", cur, held);
                end
                if (bf_valid && bf_ready) begin
                    accepted_cnt++;
                    seen.push_back(cur);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_beat: got L%0d a=%0d b=%0d z=%0d, want no beat",
                                 cur[26:24], cur[23:16], cur[15:8], cur[7:1]);
                    end else begin
                        e = exp_q.pop_front();
                        check_desc($sformatf("beat%0d", seen.size() - 1), cur, e);
                    end
                end
                prev_stall = bf_valid && !bf_ready;
                held = cur;
            end
        end
    end

    // Downstream model: bf_ready and write-back acks.
    initial forever begin
        @(posedge clk);
        #1;
        bf_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (ack_mode == 0) begin
            if (accepted_cnt > acked_cnt) begin
                wb_ack = 1'b1;
                acked_cnt++;
            end else begin
                wb_ack = 1'b0;
            end
        end else if (ack_mode == 1) begin
            wb_ack = 1'b0;
        end
    end

    task automatic do_start(input bit inv);
        seen.delete();
        push_golden(inv);
        @(posedge clk); #1;
        start = 1'b1;
        inverse = inv;
        @(posedge clk); #1;
        start = 1'b0;
        inverse = !inv;
        @(negedge clk);
        check("first_valid", bf_valid, 1);
        check("busy_after_start", busy, 1);
        check("err_after_start", err, 0);
    endtask

    task automatic wait_done(input int elapsed0, output int elapsed);
        bit got;
        int beats;
        got = 1'b0;
        elapsed = elapsed0;
        for (int i = 0; i < 5000; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            elapsed++;
        end
        check("done_seen", got, 1);
        if (got) begin
            check("busy_low_at_done", busy, 0);
            check("valid_low_at_done", bf_valid, 0);
            check("queue_drained", exp_q.size(), 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            beats = accepted_cnt;
            repeat (4) @(negedge clk);
            check("no_beats_after_done", accepted_cnt - beats, 0);
            check("err_clean", err, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        bit hit;
        rst_n = 1'b0; start = 1'b0; inverse = 1'b0; bf_ready = 1'b1; wb_ack = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", bf_valid, 0);
        check_desc("rst_desc", {layer, addr_a, addr_b, zeta_idx, bf_last}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_mode = 0;

        // forward, ready=1, with a start/inverse pulse mid-run that must be ignored
        do_start(1'b0);
        repeat (300) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1;
        inverse = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(0, at);
        check("fwd_beats", seen.size(), 896);
        if (seen.size() == 896) begin
            check_desc("fwd_b0", seen[0], pack(0, 0, 128, 1, 0));
            check_desc("fwd_b1", seen[1], pack(0, 1, 129, 1, 0));
            check_desc("fwd_l0_last", seen[127], pack(0, 127, 255, 1, 1));
            check_desc("fwd_l1_b64", seen[128 + 64], pack(1, 128, 192, 3, 0));
            check_desc("fwd_l6_b2", seen[768 + 2], pack(6, 4, 6, 65, 0));
            check_desc("fwd_final", seen[895], pack(6, 253, 255, 127, 1));
        end

        // inverse, ready=1: total cycle count from first descriptor to done
        do_start(1'b1);
        wait_done(1, at);
        check("inv_total_cycles", at, 904);
        check("inv_beats", seen.size(), 896);
        if (seen.size() == 896) begin
            check_desc("inv_first", seen[0], pack(6, 0, 2, 127, 0));
            check_desc("inv_l0_b0", seen[768], pack(0, 0, 128, 1, 0));
            check_desc("inv_l0_b5", seen[768 + 5], pack(0, 5, 133, 1, 0));
            check_desc("inv_final", seen[895], pack(0, 127, 255, 1, 1));
        end

        // backpressure, forward
        rdy_rand = 1'b1;
        do_start(1'b0);
        wait_done(0, at);
        check("bp_fwd_beats", seen.size(), 896);
        rdy_rand = 1'b0;

        // drain: withhold all acks of layer 0, then release one per cycle
        ack_mode = 1;
        do_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (seen.size() >= 128) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("drain_layer0_issued", hit, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("drain_hold_valid", bf_valid, 0);
        end
        ack_mode = 0;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (acked_cnt == accepted_cnt) begin
                hit = 1'b1;
                break;
            end
            check("drain_wait_valid", bf_valid, 0);
        end
        check("drain_all_acked", hit, 1);
        check("drain_valid_at_last_ack", bf_valid, 0);
        @(negedge clk);
        check("drain_next_valid", bf_valid, 1);
        check_desc("drain_next_desc", {layer, addr_a, addr_b, zeta_idx, bf_last}, pack(1, 0, 64, 2, 0));
        wait_done(0, at);

        // wb_ack in IDLE sets sticky err; outstanding must stay 0 for the next run
        ack_mode = 2;
        @(posedge clk); #1;
        wb_ack = 1'b1;
        @(posedge clk); #1;
        wb_ack = 1'b0;
        @(negedge clk);
        check("err_set_idle", err, 1);
        check("busy_idle", busy, 0);
        repeat (3) @(negedge clk);
        check("err_sticky", err, 1);
        ack_mode = 0;
        do_start(1'b0);
        wait_done(0, at);

        // reset in the middle of layer 3
        do_start(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (seen.size() >= 3 * 128 + 10) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reach_layer3", hit, 1);
        check("layer3_active", layer, 3);
        ack_mode = 2;
        @(posedge clk); #1;
        rst_n = 1'b0;
        wb_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_err", err, 0);
        check("midrst_valid", bf_valid, 0);
        check_desc("midrst_desc", {layer, addr_a, addr_b, zeta_idx, bf_last}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q.delete();
        acked_cnt = accepted_cnt;
        ack_mode = 0;
        repeat (3) @(negedge clk);
        check("post_rst_idle_valid", bf_valid, 0);
        check("post_rst_idle_busy", busy, 0);

        // recovery: inverse under backpressure
        rdy_rand = 1'b1;
        do_start(1'b1);
        wait_done(0, at);
        check("bp_inv_beats", seen.size(), 896);
        rdy_rand = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
